data_mem_access_unit: RTL and testbench

- Pipeline stage directly downstream of the memory-stage controller in the ARM32 pipeline.
- Consumes the controller's decoded mem_w_en, load/store, destination and register-write controls, plus the ALU result (address or data) and the store data.
- Performs word-wide data-memory accesses over a req/gnt/rvalid bus and stalls upstream while an access is in flight.
- Produces a registered writeback packet for the register file.

---
 rtl/data_mem_access_unit.sv | 136 +++++++++++++
 tb/tb_data_mem_access_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// Data-memory access stage: issues word accesses on a req/gnt/rvalid bus,
// stalls upstream while busy, and emits a registered writeback packet.
module data_mem_access_unit #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        branch_tag_in,
  input  logic        branch_ref_global,
  input  logic        mem_w_en,
  input  logic        mem_r_en,
  input  logic        w_en_in,
  input  logic [3:0]  rd_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall_out,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [3:0]       rd_q;

  logic live;
  logic is_mem;
  logic misaligned;
  logic start;
  logic timeout_hit;
  logic store_done;
  logic load_done;

  // A live instruction is one accepted in IDLE whose branch tag is current.
  assign live        = (state == IDLE) && valid_in && (branch_tag_in == branch_ref_global);
  assign is_mem      = mem_w_en || mem_r_en;
  assign misaligned  = (alu_result[1:0] != 2'b00);
  assign start       = live && is_mem && !misaligned;
  // Hit on the TIMEOUT-th cycle in REQ/WAIT so the request is held at most TIMEOUT cycles.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign store_done  = (state == REQ) && bus_gnt && we_q;
  assign load_done   = (state == WAIT) && bus_rvalid;

  // Bus control and status come straight from the state so reset drops them at once.
  assign stall_out = (state != IDLE);
  assign bus_req   = (state == REQ);
  assign bus_we    = (state == REQ) && we_q;
  assign bus_err   = (state == ERR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; completion takes priority over timeout in the same cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = REQ;
      REQ: begin
        if (bus_gnt)          state_next = we_q ? IDLE : WAIT;
        else if (timeout_hit) state_next = ERR;
      end
      WAIT: begin
        if (bus_rvalid)       state_next = IDLE;
        else if (timeout_hit) state_next = ERR;
      end
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Timeout counter: cleared when an access starts, counts every REQ/WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt <= '0;
    else if (start)                          cnt <= '0;
    else if (state == REQ || state == WAIT)  cnt <= cnt + CNT_W'(1);
  end

  // Access latches and writeback packet; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      rd_q      <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      align_err <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      align_err <= 1'b0;
      if (live && !is_mem) begin
        wb_valid <= 1'b1;
        wb_en    <= w_en_in;
        wb_rd    <= rd_in;
        wb_data  <= alu_result;
      end
      if (live && is_mem && misaligned) align_err <= 1'b1;
      if (start) begin
        we_q      <= mem_w_en;
        rd_q      <= rd_in;
        bus_addr  <= alu_result;
        bus_wdata <= store_data;
      end
      if (store_done) wb_valid <= 1'b1;
      if (load_done) begin
        wb_valid <= 1'b1;
        wb_en    <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: directed scenarios plus randomized
// instruction stream checked against a transaction-level memory model.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in, branch_tag_in, branch_ref_global;
  logic        mem_w_en, mem_r_en, w_en_in;
  logic [3:0]  rd_in;
  logic [31:0] alu_result, store_data;
  logic        stall_out, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        wb_valid, wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        align_err, bus_err;

  int total = 0;
  int bad   = 0;

  data_mem_access_unit #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .branch_tag_in(branch_tag_in),
    .branch_ref_global(branch_ref_global), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .w_en_in(w_en_in), .rd_in(rd_in), .alu_result(alu_result), .store_data(store_data),
    .stall_out(stall_out), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: the bench's slave on the bus, with its own storage.
  bit          fixed_mode = 1'b0;
  bit          never_gnt  = 1'b0;
  int          gnt_delay  = 0;
  int          rd_delay   = 0;
  logic [31:0] resp_mem [logic [31:0]];

  initial begin : responder
    int          req_cycles;
    bit          rd_pending;
    int          rd_wait;
    logic [31:0] rdata_q;
    bit          grant;
    req_cycles = 0; rd_pending = 0; rd_wait = 0; rdata_q = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (!rst_n) begin
        rd_pending = 0; req_cycles = 0;
      end else if (rd_pending) begin
        if (rd_wait == 0) begin
          bus_rvalid = 1'b1; bus_rdata = rdata_q; rd_pending = 0;
        end else rd_wait--;
      end else if (bus_req) begin
        grant = never_gnt ? 1'b0 : fixed_mode ? (req_cycles == gnt_delay) : ($urandom_range(0, 2) == 0);
        req_cycles++;
        if (grant) begin
          bus_gnt = 1'b1; req_cycles = 0;
          if (bus_we) resp_mem[bus_addr] = bus_wdata;
          else begin
            rd_pending = 1;
            rd_wait = fixed_mode ? rd_delay : $urandom_range(0, 3);
            rdata_q = resp_mem.exists(bus_addr) ? resp_mem[bus_addr] : dflt(bus_addr);
          end
        end
      end
    end
  end

  // Reference model: architectural memory plus last writeback register/data.
  logic [31:0] model_mem [logic [31:0]];
  bit          have_last = 1'b0;
  logic [3:0]  last_rd;
  logic [31:0] last_data;

  task automatic idle_inputs();
    valid_in = 1'b0;
    branch_ref_global = 1'($urandom); branch_tag_in = 1'($urandom);
    mem_w_en = 1'($urandom); mem_r_en = 1'($urandom); w_en_in = 1'($urandom);
    rd_in = 4'($urandom); alu_result = $urandom; store_data = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, stall_out, 0);  chk({tag, "_req"}, bus_req, 0);
    chk({tag, "_we"}, bus_we, 0);        chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_wdata"}, bus_wdata, 0);  chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_wben"}, wb_en, 0);       chk({tag, "_wbrd"}, wb_rd, 0);
    chk({tag, "_wbdata"}, wb_data, 0);   chk({tag, "_align"}, align_err, 0);
    chk({tag, "_buserr"}, bus_err, 0);
  endtask

  // Issue one instruction in IDLE and check its outcome. exp_lat < 0 checks only the minimum latency.
  task automatic run_op(input bit sq, input bit we, input bit re, input bit wen,
                        input logic [3:0] rd, input logic [31:0] a, input logic [31:0] sd,
                        input int exp_lat);
    int          kind;  // 0 bubble, 1 writeback, 2 alignment error
    bit          is_mem, is_store;
    bit          e_en;
    logic [31:0] e_data;
    int          lat;
    is_mem = we || re;
    is_store = we;
    e_en = 1'b0; e_data = '0;
    if (sq)                  kind = 0;
    else if (!is_mem)        begin kind = 1; e_en = wen; e_data = a; end
    else if (a[1:0] != 2'b0) kind = 2;
    else if (is_store)       begin kind = 1; model_mem[a] = sd; end
    else begin
      kind = 1; e_en = 1'b1;
      e_data = model_mem.exists(a) ? model_mem[a] : dflt(a);
    end

    @(negedge clk);
    chk("idle_before_issue", stall_out, 0);
    valid_in = 1'b1;
    branch_ref_global = 1'($urandom);
    branch_tag_in = sq ? ~branch_ref_global : branch_ref_global;
    mem_w_en = we; mem_r_en = re; w_en_in = wen;
    rd_in = rd; alu_result = a; store_data = sd;
    @(negedge clk);
    idle_inputs();
    lat = 1;
    if (kind == 1 && is_mem) begin
      while (!wb_valid && lat < 300) begin
        chk("busy_stall", stall_out, 1);
        if (bus_req) begin
          chk("bus_addr", bus_addr, a);
          chk("bus_we", bus_we, is_store);
          if (is_store) chk("bus_wdata", bus_wdata, sd);
        end
        @(negedge clk);
        lat++;
      end
    end
    case (kind)
      0: begin
        chk("sq_wbv", wb_valid, 0); chk("sq_req", bus_req, 0);
        chk("sq_align", align_err, 0); chk("sq_stall", stall_out, 0);
        if (have_last) begin chk("hold_rd", wb_rd, last_rd); chk("hold_data", wb_data, last_data); end
      end
      2: begin
        chk("mis_align", align_err, 1); chk("mis_wbv", wb_valid, 0);
        chk("mis_req", bus_req, 0); chk("mis_stall", stall_out, 0);
        if (have_last) begin chk("hold_rd", wb_rd, last_rd); chk("hold_data", wb_data, last_data); end
        @(negedge clk);
        chk("mis_pulse", align_err, 0);
      end
      default: begin
        chk("wb_valid", wb_valid, 1);
        chk("wb_en", wb_en, e_en);
        if (!is_store) begin
          chk("wb_rd", wb_rd, rd); chk("wb_data", wb_data, e_data);
          have_last = 1'b1; last_rd = rd; last_data = e_data;
        end else have_last = 1'b0;
        chk("wb_stall", stall_out, 0);
        if (exp_lat >= 0)  chk("latency", lat, exp_lat);
        else if (is_store) chk("latency_min_st", lat >= 2, 1);
        else               chk("latency_min_ld", lat >= 3, 1);
        @(negedge clk);
        chk("wb_pulse", wb_valid, 0);
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    have_last = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    idle_inputs();
    #1;
    check_all_zero("reset");
    do_reset();
    check_all_zero("after_reset");

    // ALU op: latency 1.
    fixed_mode = 1'b1; gnt_delay = 0; rd_delay = 0;
    run_op(0, 0, 0, 1, 4'd3, 32'h1234, 32'h0, 1);
    // Store with grant after 2 request cycles.
    gnt_delay = 2;
    run_op(0, 1, 0, 0, 4'd1, 32'h100, 32'hDEADBEEF, 4);
    // Load, immediate grant, read data 3 cycles after grant.
    gnt_delay = 0; rd_delay = 2;
    model_mem[32'h200] = 32'hCAFEF00D;
    resp_mem[32'h200] = 32'hCAFEF00D;
    run_op(0, 0, 1, 0, 4'd5, 32'h200, 32'h0, 5);
    // Earliest-possible store and load; load reads back the earlier store.
    rd_delay = 0;
    run_op(0, 1, 1, 0, 4'd2, 32'h100, 32'h0BAD_F00D, 2);
    run_op(0, 0, 1, 0, 4'd7, 32'h100, 32'h0, 3);
    // Squashed store, misaligned load.
    run_op(1, 1, 0, 0, 4'd4, 32'h300, 32'h11111111, -1);
    run_op(0, 0, 1, 0, 4'd6, 32'h202, 32'h0, -1);

    // Timeout: grant never comes.
    never_gnt = 1'b1;
    @(negedge clk);
    valid_in = 1'b1; branch_ref_global = 1'b0; branch_tag_in = 1'b0;
    mem_w_en = 1'b0; mem_r_en = 1'b1; rd_in = 4'd9; alu_result = 32'h400;
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (bus_req && n < 200) begin n++; @(negedge clk); end
    chk("timeout_req_cycles", n, 64);
    chk("timeout_buserr", bus_err, 1);
    chk("timeout_req", bus_req, 0);
    repeat (5) @(negedge clk);
    chk("err_sticky", bus_err, 1);
    chk("err_stall", stall_out, 1);
    never_gnt = 1'b0;
    do_reset();
    check_all_zero("after_err_reset");

    // Reset while a load sits in WAIT.
    gnt_delay = 0; rd_delay = 10;
    @(negedge clk);
    valid_in = 1'b1; branch_ref_global = 1'b1; branch_tag_in = 1'b1;
    mem_w_en = 1'b0; mem_r_en = 1'b1; rd_in = 4'd8; alu_result = 32'h500;
    @(negedge clk);
    idle_inputs();
    chk("midload_req", bus_req, 1);
    repeat (2) @(negedge clk);
    chk("midload_wait_stall", stall_out, 1);
    chk("midload_wait_req", bus_req, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", bus_req, 0);
    chk("async_rst_wbv", wb_valid, 0);
    chk("async_rst_stall", stall_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    have_last = 1'b0;
    run_op(0, 0, 0, 1, 4'd10, 32'hA5A5_0001, 32'h0, 1);

    // Randomized instruction stream with random bus timing.
    fixed_mode = 1'b0;
    for (int i = 0; i < 150; i++) begin
      int          k;
      bit          sq;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      sq = ($urandom_range(0, 7) == 0);
      a = 32'h1000 + {26'($urandom_range(0, 15)), 2'b00};
      if (k == 9) a[1:0] = 2'($urandom_range(1, 3));
      if (k <= 2)
        run_op(sq, 0, 0, 1'($urandom), 4'($urandom), $urandom, $urandom, 1);
      else if (k <= 5)
        run_op(sq, 1, 1'($urandom), 1'($urandom), 4'($urandom), a, $urandom, -1);
      else
        run_op(sq, 1'(k == 9 && $urandom_range(0, 1) == 1), 1, 1'($urandom), 4'($urandom), a, $urandom, -1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
